// File: rtl/miriscv_irq_pkg.sv
// ============================================================================
// miriscv_irq_pkg : shared types and constants for the interrupt controller
// Rev 1.0
// ============================================================================
`default_nettype none

package miriscv_irq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_FIN   = 2'd2
  } irq_state_e;

  localparam int unsigned DEF_CAUSE_BASE = 16;
  localparam logic        CAUSE_MSB      = 1'b1;

endpackage

`default_nettype wire

// File: rtl/miriscv_irq_arb.sv
// ============================================================================
// miriscv_irq_arb : combinational fixed-priority / round-robin channel picker
// Rev 1.0
// ============================================================================
`default_nettype none

module miriscv_irq_arb #(
  parameter int unsigned NUM_IRQ = 32,
  parameter bit          ARB_RR  = 1'b0,
  localparam int unsigned IDW    = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic [NUM_IRQ-1:0] eligible_i,
  input  logic [IDW-1:0]     rr_ptr_i,
  output logic [IDW-1:0]     id_o,
  output logic               valid_o
);

  int idx;

  // Scan from the far end so the last hit (smallest offset) wins, avoiding a break.
  always_comb begin
    id_o    = '0;
    valid_o = |eligible_i;
    idx     = 0;
    for (int k = int'(NUM_IRQ) - 1; k >= 0; k--) begin
      if (ARB_RR) idx = (int'(rr_ptr_i) + k) % int'(NUM_IRQ);
      else        idx = k;
      if (eligible_i[IDW'(idx)]) id_o = IDW'(idx);
    end
  end

endmodule

`default_nettype wire

// File: rtl/miriscv_irq_ctrl.sv
// ============================================================================
// miriscv_irq_ctrl : N-channel interrupt controller feeding the miriscv core
// Rev 1.0
// ============================================================================
`default_nettype none

module miriscv_irq_ctrl
  import miriscv_irq_pkg::*;
#(
  parameter int unsigned          NUM_IRQ    = 32,
  parameter logic [NUM_IRQ-1:0]   EDGE_SENS  = '0,
  parameter bit                   ARB_RR     = 1'b0,
  parameter int unsigned          CAUSE_BASE = DEF_CAUSE_BASE
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_IRQ-1:0] int_req_i,
  input  logic [NUM_IRQ-1:0] mie_i,
  output logic               int_o,
  output logic [31:0]        mcause_o,
  input  logic               int_rst_i,
  output logic [NUM_IRQ-1:0] int_fin_o
);

  localparam int unsigned IDW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  irq_state_e         state_q;
  logic [NUM_IRQ-1:0] prev_q;
  logic [NUM_IRQ-1:0] pend_q;
  logic [NUM_IRQ-1:0] pend_d;
  logic [NUM_IRQ-1:0] fin_q;
  logic [IDW-1:0]     id_q;
  logic [IDW-1:0]     rr_ptr_q;
  logic [IDW-1:0]     rr_ptr_d;
  logic               int_q;
  logic [31:0]        mcause_q;

  logic [NUM_IRQ-1:0] eligible;
  logic [IDW-1:0]     arb_id;
  logic               arb_valid;

  // fin_q is one-hot on the served channel only during FIN, so it doubles as the
  // edge-pending clear; a fresh edge in that same cycle is OR-ed in after the clear.
  always_comb begin
    pend_d = (EDGE_SENS & ((pend_q & ~fin_q) | (int_req_i & ~prev_q)))
           | (~EDGE_SENS & int_req_i);
    rr_ptr_d = (id_q == IDW'(NUM_IRQ - 1)) ? '0 : id_q + IDW'(1);
  end

  assign eligible = pend_q & mie_i;

  miriscv_irq_arb #(
    .NUM_IRQ (NUM_IRQ),
    .ARB_RR  (ARB_RR)
  ) u_arb (
    .eligible_i (eligible),
    .rr_ptr_i   (rr_ptr_q),
    .id_o       (arb_id),
    .valid_o    (arb_valid)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      prev_q   <= '0;
      pend_q   <= '0;
      fin_q    <= '0;
      id_q     <= '0;
      rr_ptr_q <= '0;
      int_q    <= 1'b0;
      mcause_q <= '0;
    end else begin
      prev_q <= int_req_i;
      pend_q <= pend_d;
      unique case (state_q)
        ST_IDLE: begin
          if (arb_valid) begin
            id_q     <= arb_id;
            int_q    <= 1'b1;
            mcause_q <= {CAUSE_MSB, 31'(CAUSE_BASE) + 31'(arb_id)};
            state_q  <= ST_SERVE;
          end
        end
        ST_SERVE: begin
          if (int_rst_i) begin
            int_q    <= 1'b0;
            mcause_q <= '0;
            fin_q    <= NUM_IRQ'(1) << id_q;
            rr_ptr_q <= rr_ptr_d;
            state_q  <= ST_FIN;
          end
        end
        ST_FIN: begin
          fin_q   <= '0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign int_o     = int_q;
  assign mcause_o  = mcause_q;
  assign int_fin_o = fin_q;

endmodule

`default_nettype wire

// File: tb/tb_miriscv_irq_ctrl.sv
// ============================================================================
// tb_miriscv_irq_ctrl : directed self-checking bench (edge/fixed and level/RR)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_miriscv_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [31:0] req0 = '0;
  logic [31:0] mie0 = '1;
  logic        ack0 = 1'b0;
  logic        int0;
  logic [31:0] cause0;
  logic [31:0] fin0;

  logic [7:0]  req1 = '0;
  logic [7:0]  mie1 = '1;
  logic        ack1 = 1'b0;
  logic        int1;
  logic [31:0] cause1;
  logic [7:0]  fin1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  miriscv_irq_ctrl #(
    .NUM_IRQ    (32),
    .EDGE_SENS  (32'hFFFF_FFFF),
    .ARB_RR     (1'b0),
    .CAUSE_BASE (16)
  ) u_dut_edge (
    .clk_i     (clk),
    .rst_i     (rst),
    .int_req_i (req0),
    .mie_i     (mie0),
    .int_o     (int0),
    .mcause_o  (cause0),
    .int_rst_i (ack0),
    .int_fin_o (fin0)
  );

  miriscv_irq_ctrl #(
    .NUM_IRQ    (8),
    .EDGE_SENS  (8'h00),
    .ARB_RR     (1'b1),
    .CAUSE_BASE (16)
  ) u_dut_rr (
    .clk_i     (clk),
    .rst_i     (rst),
    .int_req_i (req1),
    .mie_i     (mie1),
    .int_o     (int1),
    .mcause_o  (cause1),
    .int_rst_i (ack1),
    .int_fin_o (fin1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Acknowledge the in-flight interrupt on the edge DUT and check the finish pulse.
  task automatic ack_edge(input string tag, input logic [31:0] fin_exp);
    ack0 = 1'b1;
    tick();
    ack0 = 1'b0;
    check({tag, "_fin"}, fin0, fin_exp);
    check({tag, "_int_lo"}, {31'd0, int0}, 32'd0);
    tick();
    check({tag, "_fin_clr"}, fin0, 32'd0);
  endtask

  logic [31:0] rr_cause [4] = '{32'h8000_0011, 32'h8000_0012, 32'h8000_0011, 32'h8000_0012};
  logic [7:0]  rr_fin   [4] = '{8'h02, 8'h04, 8'h02, 8'h04};

  initial begin
    // Reset state
    tick();
    check("rst_int", {31'd0, int0}, 32'd0);
    check("rst_cause", cause0, 32'd0);
    check("rst_fin", fin0, 32'd0);
    check("rst_int_rr", {31'd0, int1}, 32'd0);
    rst = 1'b0;
    tick();

    // Single edge request on channel 5: int_o two edges after the request
    req0 = 32'h20;
    tick();
    req0 = '0;
    check("s5_lat1", {31'd0, int0}, 32'd0);
    tick();
    check("s5_int", {31'd0, int0}, 32'd1);
    check("s5_cause", cause0, 32'h8000_0015);
    ack_edge("s5", 32'h20);
    tick();
    check("s5_stay_lo", {31'd0, int0}, 32'd0);

    // Ack in IDLE is ignored
    ack0 = 1'b1;
    tick();
    ack0 = 1'b0;
    check("idle_ack_fin", fin0, 32'd0);
    tick();
    check("idle_ack_int", {31'd0, int0}, 32'd0);

    // Masking: pending is retained until enabled
    mie0 = ~32'h20;
    req0 = 32'h20;
    tick();
    req0 = '0;
    tick();
    tick();
    check("mask_no_int", {31'd0, int0}, 32'd0);
    mie0 = '1;
    tick();
    check("mask_int", {31'd0, int0}, 32'd1);
    check("mask_cause", cause0, 32'h8000_0015);
    ack_edge("mask", 32'h20);

    // Fixed priority: 3 then 9; mask changes during SERVE must not disturb it
    req0 = 32'h208;
    tick();
    req0 = '0;
    tick();
    check("fp3_int", {31'd0, int0}, 32'd1);
    check("fp3_cause", cause0, 32'h8000_0013);
    mie0 = '0;
    tick();
    check("fp3_hold_int", {31'd0, int0}, 32'd1);
    check("fp3_hold_cause", cause0, 32'h8000_0013);
    mie0 = '1;
    ack_edge("fp3", 32'h8);
    tick();
    check("fp9_int", {31'd0, int0}, 32'd1);
    check("fp9_cause", cause0, 32'h8000_0019);
    ack_edge("fp9", 32'h200);
    tick();
    check("fp_done", {31'd0, int0}, 32'd0);

    // Edge re-arrival on the served channel during FIN
    req0 = 32'h20;
    tick();
    req0 = '0;
    tick();
    check("re_int1", {31'd0, int0}, 32'd1);
    ack0 = 1'b1;
    tick();
    ack0 = 1'b0;
    check("re_fin", fin0, 32'h20);
    req0 = 32'h20;
    tick();
    req0 = '0;
    check("re_fin_clr", fin0, 32'd0);
    tick();
    check("re_int2", {31'd0, int0}, 32'd1);
    check("re_cause2", cause0, 32'h8000_0015);
    ack_edge("re2", 32'h20);
    tick();
    check("re_done", {31'd0, int0}, 32'd0);

    // Round-robin over level channels 1 and 2
    req1 = 8'h06;
    tick();
    for (int n = 0; n < 4; n++) begin
      tick();
      check("rr_int", {31'd0, int1}, 32'd1);
      check("rr_cause", cause1, rr_cause[n]);
      ack1 = 1'b1;
      tick();
      ack1 = 1'b0;
      check("rr_fin", {24'd0, fin1}, {24'd0, rr_fin[n]});
      if (n == 3) req1 = '0;
      tick();
      check("rr_fin_clr", {24'd0, fin1}, 32'd0);
    end
    tick();
    tick();
    check("rr_done", {31'd0, int1}, 32'd0);

    // Asynchronous reset mid-SERVE
    req0 = 32'h20;
    tick();
    req0 = '0;
    tick();
    check("ar_int_pre", {31'd0, int0}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check("ar_int", {31'd0, int0}, 32'd0);
    check("ar_cause", cause0, 32'd0);
    check("ar_fin", fin0, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("ar_after_fin", fin0, 32'd0);
    tick();
    tick();
    check("ar_after_int", {31'd0, int0}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/miriscv_irq_ctrl.md
# miriscv_irq_ctrl

Parametrised interrupt controller between the peripheral interrupt lines and the miriscv core's interrupt/CSR logic. It replaces the single-line request/finish scheme with N channels, per-channel edge or level sensitivity, masking, and fixed-priority or round-robin arbitration. It presents one interrupt at a time to the core with its cause code, waits for the core's return-from-handler acknowledge, then pulses a per-channel finish line back to the source.

## Interface
- `NUM_IRQ`, 32: number of interrupt channels, 1..32.
- `EDGE_SENS`, `'0`: NUM_IRQ-bit vector; bit i = 1 makes channel i rising-edge sensitive, 0 makes it level sensitive.
- `ARB_RR`, 0: 0 = fixed priority (lowest index wins); 1 = round-robin.
- `CAUSE_BASE`, 16: cause code of channel 0; channel i reports `CAUSE_BASE + i`.

- `clk_i`  in  1  clock; all state on rising edge.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `int_req_i`  in  NUM_IRQ  interrupt requests from peripherals.
- `mie_i`  in  NUM_IRQ  per-channel enable mask from the CSR file.
- `int_o`  out  1  interrupt request to the core.
- `mcause_o`  out  32  cause for the granted channel: `{1'b1, 31'(CAUSE_BASE + id)}`.
- `int_rst_i`  in  1  core acknowledge (mret of the served interrupt), one-cycle pulse.
- `int_fin_o`  out  NUM_IRQ  one-hot, one-cycle finish pulse to the served source.

## Operation
- Pending vector `pend`:
  - Edge channels set on a sampled 0->1 transition of `int_req_i[i]`, using a registered previous-value vector.
  - Level channels follow the registered `int_req_i[i]`.
- Eligible = `pend & mie_i`.
- FSM states:
  - IDLE: if eligible != 0, latch arbitration winner `id` and go to SERVE.
  - SERVE: `int_o` = 1 and `mcause_o` is held. `int_rst_i` moves the FSM to FIN.
  - FIN: `int_fin_o[id]` = 1 for exactly one cycle. Edge `pend[id]` clears. Always return to IDLE.
- Arbitration:
  - Fixed priority: lowest eligible index.
  - Round-robin: first eligible index at or after pointer `rr_ptr`, wrapping at NUM_IRQ-1 -> 0. `rr_ptr` <= `id`+1 (mod NUM_IRQ) on entering FIN.
- Width rule: `id` is `$clog2(NUM_IRQ)` bits (minimum 1). Cause addition is done in 31 bits, no overflow for the legal range.

## Timing
- Reset values:
  - `int_o` = 0, `mcause_o` = 0, `int_fin_o` = 0.
  - `pend` = 0, prev-sample = 0, `rr_ptr` = 0, state IDLE.
- Latency: request high before edge N -> `pend` set after edge N -> SERVE and `int_o` = 1 after edge N+1 (2 cycles).
- `int_rst_i` sampled high in SERVE -> `int_fin_o` pulse during the next cycle -> IDLE one cycle later. Minimum back-to-back spacing is 3 cycles between `int_o` rises.
- `int_rst_i` in IDLE or FIN is ignored.
- `mie_i` or `int_req_i` changes during SERVE do not change `id` or `mcause_o`; the in-flight interrupt completes.
- A new edge on channel `id` in the same cycle as the FIN clear: set wins, and the edge is not lost.
- Level channel still high after FIN re-triggers. Sources must drop the request on `int_fin_o`.
- Reset asserted mid-SERVE: all outputs drop to reset values immediately (asynchronous). No finish pulse is issued.

## Structure
- Package `miriscv_irq_pkg`: state enum (IDLE/SERVE/FIN), default `CAUSE_BASE`, cause-MSB constant.
- One natural sub-module: `miriscv_irq_arb` (combinational priority/round-robin picker with parameters NUM_IRQ and ARB_RR; inputs eligible and `rr_ptr`; outputs `id` and valid).

## Test plan
- Single edge request: NUM_IRQ=32, EDGE_SENS all 1, `mie_i`=all 1, pulse `int_req_i[5]` -> `int_o` high 2 cycles later with `mcause_o`=32'h8000_0015. Then `int_rst_i` -> `int_fin_o`=32'h20 for one cycle, and `int_o` stays low.
- Masking: `mie_i[5]`=0, edge on channel 5 -> no `int_o`. Later set `mie_i[5]`=1 -> `int_o` with cause 0x15 (pending retained).
- Fixed priority: simultaneous edges on channels 3 and 9 -> served 3 (cause 0x13), then 9 (cause 0x19), two finish pulses in that order.
- Round-robin: ARB_RR=1, level channels 1 and 2 held high, ack each -> grant order 1, 2, 1, 2. The sources drop the lines after the fourth finish.
- Edge re-arrival during FIN: new edge on channel 5 in the FIN cycle -> second SERVE of channel 5 follows.
- Reset mid-SERVE: assert `rst_i` while `int_o`=1 -> `int_o`, `mcause_o`, and `int_fin_o` are 0 in the same cycle. After release, no interrupt appears without a new edge.
